// File: rtl/mem_bus_ctrl_pkg.sv
// rtl/mem_bus_ctrl_pkg.sv - shared encodings for the Mem-stage data bus bridge
package mem_bus_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        MBC_IDLE = 2'd0,
        MBC_REQ  = 2'd1,
        MBC_RSP  = 2'd2,
        MBC_DONE = 2'd3
    } mbc_state_t;

    // Access size codes, identical to the low two bits of funct3
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Opcodes of the instructions this block serves
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Store size arrives as the Mem stage one-hot write mask; unknown codes fall back to a byte
    function automatic logic [1:0] onehot_to_size(input logic [3:0] i_oh);
        logic [1:0] w_sz;
        case (i_oh)
            4'b1000: w_sz = SZ_D;
            4'b0100: w_sz = SZ_W;
            4'b0010: w_sz = SZ_H;
            default: w_sz = SZ_B;
        endcase
        return w_sz;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_lane_align.sv
// rtl/mem_bus_ctrl_lane_align.sv - byte strobes, misalign detect and lane shifts for one access
module mem_lane_align
    import mem_bus_ctrl_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [1:0]        i_size,
    input  logic [2:0]        i_offset,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [7:0]        o_strb,
    output logic              o_misalign,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [7:0]  w_mask;
    logic [2:0]  w_align;
    logic [15:0] w_wide;
    logic [5:0]  w_shift;

    // Size to byte mask and natural-alignment mask; shifting into 16 bits exposes lane overflow
    always_comb begin
        w_mask  = 8'h01;
        w_align = 3'b000;
        case (i_size)
            SZ_B: begin w_mask = 8'h01; w_align = 3'b000; end
            SZ_H: begin w_mask = 8'h03; w_align = 3'b001; end
            SZ_W: begin w_mask = 8'h0F; w_align = 3'b011; end
            SZ_D: begin w_mask = 8'hFF; w_align = 3'b111; end
            default: begin w_mask = 8'h01; w_align = 3'b000; end
        endcase
        w_wide     = {8'h00, w_mask} << i_offset;
        w_shift    = {i_offset, 3'b000};
        o_strb     = w_wide[7:0];
        o_misalign = (|w_wide[15:8]) | (|(i_offset & w_align));
        o_wdata    = i_wdata << w_shift;
        o_rdata    = i_rdata >> w_shift;
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - bridges Mem-stage loads/stores onto a valid/ready data bus
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              LoadIn,
    input  logic              StoreIn,
    input  logic [ADDR_W-1:0] RaddrIn,
    input  logic [ADDR_W-1:0] WaddrIn,
    input  logic [DATA_W-1:0] WdataIn,
    input  logic [3:0]        SizeIn,
    input  logic [2:0]        Funct3In,
    output logic [DATA_W-1:0] RdataOut,
    output logic              StallOut,
    output logic              ErrOut,
    output logic              BusReqValid,
    input  logic              BusReqReady,
    output logic              BusReqWrite,
    output logic [ADDR_W-1:0] BusReqAddr,
    output logic [DATA_W-1:0] BusReqWdata,
    output logic [7:0]        BusReqStrb,
    input  logic              BusRspValid,
    input  logic [DATA_W-1:0] BusRspData,
    input  logic              BusRspErr
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    mbc_state_t        r_state;
    mbc_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [1:0]        r_size;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [7:0]        r_strb;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_start;
    logic [ADDR_W-1:0] w_in_addr;
    logic [1:0]        w_in_size;
    logic [1:0]        w_al_size;
    logic [2:0]        w_al_off;
    logic [7:0]        w_strb;
    logic              w_misalign;
    logic [DATA_W-1:0] w_wdata_sh;
    logic [DATA_W-1:0] w_rdata_sh;
    logic              w_timeout;
    logic              w_unused;

    // Sign/zero-extension is done upstream, so the unsigned bit of funct3 is not needed here
    assign w_unused = Funct3In[2];

    // A simultaneous load and store is served as the store
    assign w_start   = LoadIn | StoreIn;
    assign w_in_addr = StoreIn ? WaddrIn : RaddrIn;
    assign w_in_size = StoreIn ? onehot_to_size(SizeIn) : Funct3In[1:0];

    // The aligner looks at the incoming access in IDLE and at the latched one afterwards
    assign w_al_size = (r_state == MBC_IDLE) ? w_in_size      : r_size;
    assign w_al_off  = (r_state == MBC_IDLE) ? w_in_addr[2:0] : r_addr[2:0];

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .i_size     (w_al_size),
        .i_offset   (w_al_off),
        .i_wdata    (WdataIn),
        .i_rdata    (BusRspData),
        .o_strb     (w_strb),
        .o_misalign (w_misalign),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_rdata_sh)
    );

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= MBC_IDLE;
        else     r_state <= w_next;
    end

    // Next state plus stall/valid; stall is combinational in IDLE so the first cycle is held
    always_comb begin
        w_next      = r_state;
        StallOut    = 1'b0;
        BusReqValid = 1'b0;
        case (r_state)
            MBC_IDLE: begin
                StallOut = w_start;
                if (w_start) w_next = w_misalign ? MBC_DONE : MBC_REQ;
            end
            MBC_REQ: begin
                StallOut    = 1'b1;
                BusReqValid = 1'b1;
                if (BusReqReady) w_next = MBC_RSP;
            end
            MBC_RSP: begin
                StallOut = 1'b1;
                if (BusRspValid || w_timeout) w_next = MBC_DONE;
            end
            MBC_DONE: w_next = MBC_IDLE;
            default:  w_next = MBC_IDLE;
        endcase
    end

    // Request latch, response capture, error pulse and RSP wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= SZ_B;
            r_wdata <= '0;
            r_rdata <= '0;
            r_strb  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                MBC_IDLE: begin
                    r_err <= 1'b0;
                    if (w_start) begin
                        r_addr  <= w_in_addr;
                        r_write <= StoreIn;
                        r_size  <= w_in_size;
                        r_wdata <= w_wdata_sh;
                        r_strb  <= w_strb;
                        if (w_misalign) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end
                    end
                end
                MBC_REQ: begin
                    if (BusReqReady) r_cnt <= '0;
                end
                MBC_RSP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (BusRspValid) begin
                        r_rdata <= r_write ? '0 : w_rdata_sh;
                        r_err   <= BusRspErr;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                default: r_err <= 1'b0;
            endcase
        end
    end

    assign RdataOut    = r_rdata;
    assign ErrOut      = r_err;
    assign BusReqWrite = r_write;
    assign BusReqAddr  = {r_addr[ADDR_W-1:3], 3'b000};
    assign BusReqWdata = r_wdata;
    assign BusReqStrb  = r_strb;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - directed self-checking bench for mem_bus_ctrl
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        LoadIn, StoreIn;
    logic [63:0] RaddrIn, WaddrIn, WdataIn;
    logic [3:0]  SizeIn;
    logic [2:0]  Funct3In;
    logic [63:0] RdataOut;
    logic        StallOut, ErrOut;
    logic        BusReqValid, BusReqReady, BusReqWrite;
    logic [63:0] BusReqAddr, BusReqWdata;
    logic [7:0]  BusReqStrb;
    logic        BusRspValid;
    logic [63:0] BusRspData;
    logic        BusRspErr;

    int n_cmp = 0;
    int n_bad = 0;

    mem_bus_ctrl #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .LoadIn      (LoadIn),
        .StoreIn     (StoreIn),
        .RaddrIn     (RaddrIn),
        .WaddrIn     (WaddrIn),
        .WdataIn     (WdataIn),
        .SizeIn      (SizeIn),
        .Funct3In    (Funct3In),
        .RdataOut    (RdataOut),
        .StallOut    (StallOut),
        .ErrOut      (ErrOut),
        .BusReqValid (BusReqValid),
        .BusReqReady (BusReqReady),
        .BusReqWrite (BusReqWrite),
        .BusReqAddr  (BusReqAddr),
        .BusReqWdata (BusReqWdata),
        .BusReqStrb  (BusReqStrb),
        .BusRspValid (BusRspValid),
        .BusRspData  (BusRspData),
        .BusRspErr   (BusRspErr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one access from an IDLE cycle (entered at posedge+1) through DONE, acting as the bus
    task automatic run_access(
        input  logic        ld, st,
        input  logic [63:0] raddr, waddr, wdata,
        input  logic [3:0]  size,
        input  logic [2:0]  f3,
        input  int          rdy_wait, rsp_wait,
        input  logic        no_rsp,
        input  logic [63:0] rdata,
        input  logic        rerr,
        output int          stalls,
        output logic        seen_valid,
        output logic        stable,
        output logic [63:0] q_addr, q_wdata,
        output logic [7:0]  q_strb,
        output logic        q_write,
        output logic [63:0] q_rdata,
        output logic        q_err
    );
        int   req_n = 0;
        int   rsp_n = 0;
        logic in_rsp = 1'b0;
        logic done = 1'b0;
        logic hs;
        stalls = 0; seen_valid = 1'b0; stable = 1'b1;
        q_addr = '0; q_wdata = '0; q_strb = '0; q_write = 1'b0; q_rdata = '0; q_err = 1'b0;
        LoadIn = ld; StoreIn = st; RaddrIn = raddr; WaddrIn = waddr; WdataIn = wdata;
        SizeIn = size; Funct3In = f3; BusRspData = rdata; BusRspErr = rerr;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            #1;
            BusReqReady = 1'b0;
            BusRspValid = 1'b0;
            hs = 1'b0;
            if (StallOut) stalls++;
            else begin
                done = 1'b1;
                q_rdata = RdataOut;
                q_err = ErrOut;
                LoadIn = 1'b0;
                StoreIn = 1'b0;
            end
            if (BusReqValid) begin
                if (!seen_valid) begin
                    q_addr = BusReqAddr; q_wdata = BusReqWdata; q_strb = BusReqStrb; q_write = BusReqWrite;
                end else if (q_addr !== BusReqAddr || q_wdata !== BusReqWdata ||
                             q_strb !== BusReqStrb || q_write !== BusReqWrite) begin
                    stable = 1'b0;
                end
                seen_valid = 1'b1;
                BusReqReady = (req_n == rdy_wait);
                hs = BusReqReady;
                req_n++;
            end
            if (in_rsp) begin
                BusRspValid = !no_rsp && (rsp_n == rsp_wait);
                rsp_n++;
            end
            @(posedge clk);
            if (hs) in_rsp = 1'b1;
        end
        BusReqReady = 1'b0;
        BusRspValid = 1'b0;
        if (!done) check_eq("access_done", 64'd0, 64'd1);
        #1;
    endtask

    int          st_n;
    logic        sv, stb, qw, qe;
    logic [63:0] qa, qd, qr;
    logic [7:0]  qs;

    initial begin
        rst = 1'b1;
        LoadIn = 0; StoreIn = 0; RaddrIn = 0; WaddrIn = 0; WdataIn = 0; SizeIn = 0; Funct3In = 0;
        BusReqReady = 0; BusRspValid = 0; BusRspData = 0; BusRspErr = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_stall", StallOut, 0);
        check_eq("rst_valid", BusReqValid, 0);
        check_eq("rst_err", ErrOut, 0);
        check_eq("rst_rdata", RdataOut, 0);
        check_eq("rst_strb", BusReqStrb, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Load double, zero bus wait
        run_access(1, 0, 64'h80000010, 0, 0, 4'b0000, 3'b011, 0, 0, 0, 64'h1122334455667788, 0,
                   st_n, sv, stb, qa, qd, qs, qw, qr, qe);
        check_eq("ld_d_addr", qa, 64'h80000010);
        check_eq("ld_d_strb", qs, 8'hFF);
        check_eq("ld_d_write", qw, 0);
        check_eq("ld_d_rdata", qr, 64'h1122334455667788);
        check_eq("ld_d_stall", st_n, 3);
        check_eq("ld_d_err", qe, 0);
        check_eq("err_clear", ErrOut, 0);

        // Reset while waiting in RSP
        LoadIn = 1; StoreIn = 0; RaddrIn = 64'h80000018; Funct3In = 3'b011;
        @(posedge clk); #1;
        BusReqReady = 1;
        @(posedge clk); #1;
        BusReqReady = 0;
        check_eq("rsp_stall", StallOut, 1);
        rst = 1; LoadIn = 0;
        #1;
        check_eq("mid_rst_valid", BusReqValid, 0);
        check_eq("mid_rst_stall", StallOut, 0);
        check_eq("mid_rst_rdata", RdataOut, 0);
        check_eq("mid_rst_strb", BusReqStrb, 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        // Load word after reset
        run_access(1, 0, 64'h8000000C, 0, 0, 4'b0000, 3'b010, 0, 0, 0, 64'h89ABCDEF01234567, 0,
                   st_n, sv, stb, qa, qd, qs, qw, qr, qe);
        check_eq("ld_w_addr", qa, 64'h80000008);
        check_eq("ld_w_strb", qs, 8'hF0);
        check_eq("ld_w_rdata", qr, 64'h0000000089ABCDEF);
        check_eq("ld_w_stall", st_n, 3);

        // Store byte at offset 5
        run_access(0, 1, 0, 64'h80000005, 64'hAB, 4'b0001, 3'b000, 0, 0, 0, 64'hFFFFFFFFFFFFFFFF, 0,
                   st_n, sv, stb, qa, qd, qs, qw, qr, qe);
        check_eq("st_b_strb", qs, 8'h20);
        check_eq("st_b_wdata", qd, 64'h0000AB0000000000);
        check_eq("st_b_addr", qa, 64'h80000000);
        check_eq("st_b_write", qw, 1);
        check_eq("st_b_rdata", qr, 0);

        // Load and store together: store wins
        run_access(1, 1, 64'h80000088, 64'h80000040, 64'h0123456789ABCDEF, 4'b1000, 3'b000, 0, 0, 0,
                   64'h5555555555555555, 0, st_n, sv, stb, qa, qd, qs, qw, qr, qe);
        check_eq("both_write", qw, 1);
        check_eq("both_addr", qa, 64'h80000040);
        check_eq("both_strb", qs, 8'hFF);
        check_eq("both_wdata", qd, 64'h0123456789ABCDEF);

        // Load half at offset 6
        run_access(1, 0, 64'h80000006, 0, 0, 4'b0000, 3'b001, 0, 0, 0, 64'hBEEF000000000000, 0,
                   st_n, sv, stb, qa, qd, qs, qw, qr, qe);
        check_eq("ld_h_strb", qs, 8'hC0);
        check_eq("ld_h_rdata", qr, 64'hBEEF);

        // Misaligned word at offset 6
        run_access(1, 0, 64'h80000006, 0, 0, 4'b0000, 3'b010, 0, 0, 0, 64'h1234, 0,
                   st_n, sv, stb, qa, qd, qs, qw, qr, qe);
        check_eq("mis_valid", sv, 0);
        check_eq("mis_err", qe, 1);
        check_eq("mis_rdata", qr, 0);
        check_eq("mis_stall", st_n, 1);
        check_eq("mis_err_clear", ErrOut, 0);

        // Byte load answered with a bus error
        run_access(1, 0, 64'h80000003, 0, 0, 4'b0000, 3'b100, 0, 0, 0, 64'h0000000055000000, 1,
                   st_n, sv, stb, qa, qd, qs, qw, qr, qe);
        check_eq("berr_strb", qs, 8'h08);
        check_eq("berr_err", qe, 1);
        check_eq("berr_rdata", qr, 64'h55);
        BusRspErr = 0;

        // Store word with slow accept and slow response
        run_access(0, 1, 0, 64'h80000104, 64'h00000000CAFEF00D, 4'b0100, 3'b000, 4, 2, 0, 0, 0,
                   st_n, sv, stb, qa, qd, qs, qw, qr, qe);
        check_eq("slow_stable", stb, 1);
        check_eq("slow_stall", st_n, 9);
        check_eq("slow_strb", qs, 8'hF0);
        check_eq("slow_wdata", qd, 64'hCAFEF00D00000000);
        check_eq("slow_addr", qa, 64'h80000100);

        // No response: timeout after 4 RSP cycles
        run_access(1, 0, 64'h80000020, 0, 0, 4'b0000, 3'b011, 0, 0, 1, 0, 0,
                   st_n, sv, stb, qa, qd, qs, qw, qr, qe);
        check_eq("to_stall", st_n, 6);
        check_eq("to_err", qe, 1);
        check_eq("to_rdata", qr, 0);

        // Late response in IDLE is ignored
        BusRspData = 64'hDEADBEEFDEADBEEF;
        BusRspValid = 1;
        @(posedge clk); #1;
        BusRspValid = 0;
        check_eq("late_rdata", RdataOut, 0);
        check_eq("late_err", ErrOut, 0);
        check_eq("late_stall", StallOut, 0);
        check_eq("late_valid", BusReqValid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
